// File: rtl/rr_arbiter4.sv
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Four-requester round-robin arbiter with bounded-hold preemption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int                CNT_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_idx;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_nxt_state;
  logic [3:0]       w_nxt_gnt;
  logic [1:0]       w_nxt_idx;
  logic [1:0]       w_nxt_ptr;
  logic [CNT_W-1:0] w_nxt_cnt;

  logic [1:0]       w_sel;
  logic             w_holder_req;
  logic             w_others_req;

  // Search ptr+1 .. ptr+4; descending loop so the nearest candidate wins.
  always_comb begin
    w_sel = r_ptr;
    for (int j = 3; j >= 0; j--) begin
      if (req[2'(r_ptr + 2'(j + 1))]) begin
        w_sel = 2'(r_ptr + 2'(j + 1));
      end
    end
  end

  assign w_holder_req = req[r_idx];
  assign w_others_req = |(req & ~r_gnt);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_idx   = r_idx;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        w_nxt_gnt = 4'b0000;
        w_nxt_idx = 2'b00;
        if (req != 4'b0000) begin
          w_nxt_gnt   = 4'b0001 << w_sel;
          w_nxt_idx   = w_sel;
          w_nxt_ptr   = w_sel;
          w_nxt_cnt   = '0;
          w_nxt_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_holder_req || ((r_hold_cnt == CNT_MAX) && w_others_req)) begin
          w_nxt_gnt   = 4'b0000;
          w_nxt_idx   = 2'b00;
          w_nxt_state = S_IDLE;
        end else if (r_hold_cnt != CNT_MAX) begin
          w_nxt_cnt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_gnt   = 4'b0000;
        w_nxt_idx   = 2'b00;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 4'b0000;
      r_idx      <= 2'b00;
      r_ptr      <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_gnt      <= w_nxt_gnt;
      r_idx      <= w_nxt_idx;
      r_ptr      <= w_nxt_ptr;
      r_hold_cnt <= w_nxt_cnt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = |r_gnt;

endmodule

`default_nettype wire
